// File: rtl/rom_arbiter_2p.sv
// Two-port fixed-priority arbiter in front of a registered image ROM.
// Port 0 wins by default; port 1 overrides after MAX_WAIT consecutive denials.
module rom_arbiter_2p #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 12,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rgb
);

  logic [3:0]        wait_cnt;
  logic              override;
  logic              gnt_any;
  logic [ADDR_W-1:0] addr_q;
  logic [ROM_LAT:1]  vld_pipe;
  logic [ROM_LAT:1]  port_pipe;

  always_comb begin
    override = req1 && (wait_cnt == 4'(MAX_WAIT));
    gnt1     = !rst && req1 && (override || !req0);
    gnt0     = !rst && req0 && !gnt1;
    gnt_any  = gnt0 || gnt1;
    // Idle cycles replay the last granted address so the ROM bus stays quiet.
    if (rst)       rom_addr = '0;
    else if (gnt0) rom_addr = addr0;
    else if (gnt1) rom_addr = addr1;
    else           rom_addr = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      addr_q    <= '0;
      vld_pipe  <= '0;
      port_pipe <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      if (gnt1 || !req1)
        wait_cnt <= '0;
      else if (gnt0 && wait_cnt < 4'(MAX_WAIT))
        wait_cnt <= wait_cnt + 4'd1;

      if (gnt_any) addr_q <= rom_addr;

      // Tag i travels alongside the ROM read issued i cycles ago.
      for (int i = ROM_LAT; i > 1; i--) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        port_pipe[i] <= port_pipe[i-1];
      end
      vld_pipe[1]  <= gnt_any;
      port_pipe[1] <= gnt1;

      rvalid0 <= vld_pipe[ROM_LAT] && !port_pipe[ROM_LAT];
      rvalid1 <= vld_pipe[ROM_LAT] &&  port_pipe[ROM_LAT];
      if (vld_pipe[ROM_LAT] && !port_pipe[ROM_LAT]) rdata0 <= rom_rgb;
      if (vld_pipe[ROM_LAT] &&  port_pipe[ROM_LAT]) rdata1 <= rom_rgb;
    end
  end

endmodule
